// File: rtl/calc_op_sequencer.sv
// ---------------------------------------------------------------------------
// calc_op_sequencer
//
// Purpose:
//   Steps through a small program of calculator operations. Each program
//   entry is {op[2:0], data[15:0]}. When the sequencer runs, it presents one
//   entry at a time on alu_op/alu_b. It then strobes acc_en so the
//   accumulator of the calculator takes the result. Each step takes two
//   cycles (FETCH then ISSUE). A one-cycle done pulse marks normal completion.
//
// Ports:
//   clk        in   system clock, rising edge
//   btnu       in   synchronous active-high reset (also clears program memory)
//   prog_we    in   program write strobe (honoured only while idle)
//   prog_addr  in   [2:0]  entry index to write
//   prog_op    in   [2:0]  op code for the entry
//   prog_data  in   [15:0] operand for the entry
//   len        in   [3:0]  program length, sampled with start (clamped to 8)
//   start      in   begin a run when idle (ignored with len == 0)
//   halt       in   abort a run; wins over start
//   loop       in   repeat the program (effective only with CALC_SEQ_LOOP_EN)
//   alu_op     out  [2:0]  op code to the ALU (held between runs)
//   alu_b      out  [15:0] operand to the ALU (held between runs)
//   acc_en     out  one-cycle accumulator load strobe per step
//   busy       out  high while in FETCH or ISSUE
//   done       out  one-cycle pulse on normal completion
//   step_idx   out  [2:0]  index of the entry currently on alu_op/alu_b
//
// Configuration:
//   CALC_SEQ_LOOP_EN  when defined, loop=1 restarts the program from entry 0
//                     after the last step. The run then ends only through
//                     halt or btnu. When undefined, loop is ignored.
//
// Timing (edge 0 samples start):
//   step i operands are valid from edge 1+2i.
//   acc_en is high in the cycle after edge 2+2i.
//   done is high in the cycle after edge 2L+1.
// ---------------------------------------------------------------------------
module calc_op_sequencer (
    input  logic        clk,
    input  logic        btnu,
    input  logic        prog_we,
    input  logic [2:0]  prog_addr,
    input  logic [2:0]  prog_op,
    input  logic [15:0] prog_data,
    input  logic [3:0]  len,
    input  logic        start,
    input  logic        halt,
    input  logic        loop,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_b,
    output logic        acc_en,
    output logic        busy,
    output logic        done,
    output logic [2:0]  step_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  last_q, last_d;      // index of final step, L-1
    logic [2:0]  alu_op_q, alu_op_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic [2:0]  step_idx_q, step_idx_d;
    logic        acc_en_q, acc_en_d;
    logic        done_q, done_d;
    logic        loop_hit;

    logic [18:0] mem_q [8];           // {op, data} per entry

`ifdef CALC_SEQ_LOOP_EN
    assign loop_hit = loop;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign loop_hit    = 1'b0;
`endif

    // Program memory: every entry must clear on reset, so it is a register
    // file rather than a RAM. Writes are accepted only while idle, which
    // keeps a running program stable.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (btnu) begin
                    mem_q[gi] <= '0;
                end else if (prog_we && (state_q == S_IDLE) && (prog_addr == 3'(gi))) begin
                    mem_q[gi] <= {prog_op, prog_data};
                end
            end
        end
    endgenerate

    // State register and the registered outputs
    always_ff @(posedge clk) begin
        if (btnu) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            alu_op_q   <= '0;
            alu_b_q    <= '0;
            step_idx_q <= '0;
            acc_en_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            alu_op_q   <= alu_op_d;
            alu_b_q    <= alu_b_d;
            step_idx_q <= step_idx_d;
            acc_en_q   <= acc_en_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (start && !halt && (len != 4'd0)) begin
                    // Clamp to 8 steps. The last index is L-1.
                    last_d  = len[3] ? 3'd7 : (len[2:0] - 3'd1);
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = halt ? S_IDLE : S_ISSUE;
            end
            S_ISSUE: begin
                if (halt) begin
                    state_d = S_IDLE;
                end else if (idx_q == last_q) begin
                    if (loop_hit) begin
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic. FETCH latches the entry onto the ALU bus. The strobe
    // generated in ISSUE appears in the next cycle, so the ALU always sees
    // operands that have been stable for a full cycle first.
    // The ISSUE-cycle strobe is issued even if halt arrives in the same
    // cycle. halt only prevents later steps and the done pulse.
    always_comb begin
        alu_op_d   = alu_op_q;
        alu_b_d    = alu_b_q;
        step_idx_d = step_idx_q;
        acc_en_d   = (state_q == S_ISSUE);
        done_d     = (state_q == S_DONE) && !halt;
        if ((state_q == S_FETCH) && !halt) begin
            alu_op_d   = mem_q[idx_q][18:16];
            alu_b_d    = mem_q[idx_q][15:0];
            step_idx_d = idx_q;
        end
    end

    assign busy     = (state_q == S_FETCH) || (state_q == S_ISSUE);
    assign alu_op   = alu_op_q;
    assign alu_b    = alu_b_q;
    assign step_idx = step_idx_q;
    assign acc_en   = acc_en_q;
    assign done     = done_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_op_sequencer
//
// Purpose:
//   Directed self-checking bench for calc_op_sequencer. All expected values
//   are hand-computed from the edge timing: start is sampled at edge 0,
//   operands are valid from edge 1+2i, acc_en is high after edge 2+2i, and
//   done is high after edge 2L+1.
//
// Ports: none (top-level bench).
// Configuration: the loop checks depend on CALC_SEQ_LOOP_EN.
// ---------------------------------------------------------------------------
module tb_calc_op_sequencer;

    logic        clk = 1'b0;
    logic        btnu;
    logic        prog_we;
    logic [2:0]  prog_addr;
    logic [2:0]  prog_op;
    logic [15:0] prog_data;
    logic [3:0]  len;
    logic        start;
    logic        halt;
    logic        loop;
    logic [2:0]  alu_op;
    logic [15:0] alu_b;
    logic        acc_en;
    logic        busy;
    logic        done;
    logic [2:0]  step_idx;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;

    calc_op_sequencer dut (
        .clk       (clk),
        .btnu      (btnu),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_op   (prog_op),
        .prog_data (prog_data),
        .len       (len),
        .start     (start),
        .halt      (halt),
        .loop      (loop),
        .alu_op    (alu_op),
        .alu_b     (alu_b),
        .acc_en    (acc_en),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx)
    );

    always #5 clk = ~clk;

    // Count strobes on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (acc_en) acc_cnt++;
        if (done)   done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one rising edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [2:0] a, input logic [2:0] op, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_op   = op;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // Pulse start with the given length; returns after edge 0
    task automatic go(input logic [3:0] l);
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [15:0] exp_b  [3];
    logic [2:0]  exp_op [3];
    int base_acc;
    int base_done;

    initial begin
        btnu = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_op = '0; prog_data = '0;
        len = '0; start = 1'b0; halt = 1'b0; loop = 1'b0;
        #2;
        tick(); tick();
        btnu = 1'b0;

        // ---- reset state ----
        chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
        chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
        chk("rst_acc_en", {31'd0, acc_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_step_idx", {29'd0, step_idx}, 32'd0);

        // ---- basic 3-step program ----
        exp_op[0] = 3'b010; exp_b[0] = 16'h354A;
        exp_op[1] = 3'b011; exp_b[1] = 16'h1234;
        exp_op[2] = 3'b001; exp_b[2] = 16'h1001;
        for (int i = 0; i < 3; i++) prog(3'(i), exp_op[i], exp_b[i]);
        go(4'd3);                                  // edge 0
        len = 4'd1;                                // must be ignored mid-run
        chk("run_busy_e0", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);                      // mid-run start is ignored
            tick();                                // edge 1+2i
            start = 1'b0;
            chk($sformatf("s%0d_alu_b", i), {16'd0, alu_b}, {16'd0, exp_b[i]});
            chk($sformatf("s%0d_alu_op", i), {29'd0, alu_op}, {29'd0, exp_op[i]});
            chk($sformatf("s%0d_step_idx", i), {29'd0, step_idx}, i);
            chk($sformatf("s%0d_acc_lo", i), {31'd0, acc_en}, 32'd0);
            tick();                                // edge 2+2i
            chk($sformatf("s%0d_acc_hi", i), {31'd0, acc_en}, 32'd1);
            chk($sformatf("s%0d_done_lo", i), {31'd0, done}, 32'd0);
        end
        chk("run_busy_e6", {31'd0, busy}, 32'd0);
        tick();                                    // edge 7
        chk("run_done_e7", {31'd0, done}, 32'd1);
        chk("run_acc_e7", {31'd0, acc_en}, 32'd0);
        tick();                                    // edge 8
        chk("run_done_e8", {31'd0, done}, 32'd0);
        chk("run_busy_e8", {31'd0, busy}, 32'd0);
        chk("run_hold_alu_b", {16'd0, alu_b}, 32'h1001);

        // ---- len=0 ignored, len=12 clamps to 8 ----
        base_acc = acc_cnt; base_done = done_cnt;
        go(4'd0);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        tick(); tick(); tick();
        chk("len0_acc_cnt", acc_cnt - base_acc, 32'd0);
        chk("len0_done_cnt", done_cnt - base_done, 32'd0);
        for (int i = 0; i < 8; i++) prog(3'(i), 3'(i), 16'h1000 + 16'(i));
        base_acc = acc_cnt;
        go(4'd12);                                 // edge 0
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (e == 15) chk("len12_alu_b_last", {16'd0, alu_b}, 32'h1007);
            if (e == 16) chk("len12_done_e16", {31'd0, done}, 32'd0);
            if (e == 17) chk("len12_done_e17", {31'd0, done}, 32'd1);
        end
        chk("len12_acc_cnt", acc_cnt - base_acc, 32'd8);

        // ---- halt after edge 3 ----
        tick();
        base_acc = acc_cnt; base_done = done_cnt;
        go(4'd3);                                  // edge 0
        tick(); tick(); tick();                    // edges 1..3
        halt = 1'b1;
        tick();                                    // edge 4
        halt = 1'b0;
        chk("halt_busy_e4", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 6; k++) tick();
        chk("halt_acc_cnt", acc_cnt - base_acc, 32'd2);
        chk("halt_done_cnt", done_cnt - base_done, 32'd0);

        // ---- write during run is ignored ----
        go(4'd1);                                  // edge 0, FETCH
        prog(3'd0, 3'd7, 16'h5555);                // edge 1, not idle
        tick(); tick(); tick();
        go(4'd1);
        tick();                                    // edge 1
        chk("we_ignored_alu_b", {16'd0, alu_b}, 32'h1000);
        chk("we_ignored_alu_op", {29'd0, alu_op}, 32'd0);
        tick(); tick(); tick();

        // ---- reset mid-run ----
        go(4'd3);                                  // edge 0
        tick(); tick();                            // edges 1,2
        btnu = 1'b1;
        tick();                                    // edge 3
        btnu = 1'b0;
        base_acc = acc_cnt;
        chk("mrst_alu_b", {16'd0, alu_b}, 32'd0);
        chk("mrst_alu_op", {29'd0, alu_op}, 32'd0);
        chk("mrst_acc_en", {31'd0, acc_en}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_step_idx", {29'd0, step_idx}, 32'd0);
        tick(); tick(); tick();
        chk("mrst_acc_cnt", acc_cnt - base_acc, 32'd0);
        go(4'd2);                                  // entry 1 was 1001, now cleared
        tick(); tick(); tick();                    // edge 3: step 1
        chk("mrst_rerun_alu_b", {16'd0, alu_b}, 32'd0);
        tick();
        chk("mrst_rerun_acc", {31'd0, acc_en}, 32'd1);
        tick(); tick(); tick();

        // ---- loop behaviour ----
        prog(3'd0, 3'd1, 16'hAAAA);
        prog(3'd1, 3'd2, 16'hBBBB);
        loop = 1'b1;
        base_done = done_cnt;
        go(4'd2);                                  // edge 0
`ifdef CALC_SEQ_LOOP_EN
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 1) chk("loop_b_e1", {16'd0, alu_b}, 32'hAAAA);
            if (e == 3) chk("loop_b_e3", {16'd0, alu_b}, 32'hBBBB);
            if (e == 5) chk("loop_b_e5", {16'd0, alu_b}, 32'hAAAA);
            if (e == 7) chk("loop_b_e7", {16'd0, alu_b}, 32'hBBBB);
        end
        chk("loop_done_cnt", done_cnt - base_done, 32'd0);
        chk("loop_busy", {31'd0, busy}, 32'd1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("loop_halt_busy", {31'd0, busy}, 32'd0);
        tick(); tick();
        chk("loop_halt_done", done_cnt - base_done, 32'd0);
`else
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 1) chk("noloop_b_e1", {16'd0, alu_b}, 32'hAAAA);
            if (e == 3) chk("noloop_b_e3", {16'd0, alu_b}, 32'hBBBB);
            if (e == 4) chk("noloop_busy_e4", {31'd0, busy}, 32'd0);
            if (e == 5) chk("noloop_done_e5", {31'd0, done}, 32'd1);
            if (e == 6) chk("noloop_busy_e6", {31'd0, busy}, 32'd0);
        end
        chk("noloop_done_cnt", done_cnt - base_done, 32'd1);
`endif
        loop = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
